// File: rtl/chan_emu_iq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// chan_emu_iq : I/Q loopback channel emulator (rotate, gain, offset, noise,
//               saturation, programmable delay) in the 16.384 MHz domain.
// Rev 1.0
// ============================================================================
module chan_emu_iq #(
    parameter int          DW         = 12,
    parameter int          DELAY_MAX  = 16,
    parameter int          NOISE_BITS = 6,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                         clk_16M384,
    input  logic                         rst_16M384,
    input  logic signed [DW-1:0]         in_I,
    input  logic signed [DW-1:0]         in_Q,
    input  logic                         in_valid,
    input  logic [1:0]                   cfg_rot,
    input  logic [3:0]                   cfg_gain,
    input  logic signed [7:0]            cfg_dc_I,
    input  logic signed [7:0]            cfg_dc_Q,
    input  logic                         cfg_noise_en,
    input  logic [$clog2(DELAY_MAX)-1:0] cfg_delay,
    output logic signed [DW-1:0]         out_I,
    output logic signed [DW-1:0]         out_Q,
    output logic                         out_valid,
    output logic [15:0]                  sat_cnt
);

    localparam int c_DLY_W = $clog2(DELAY_MAX);
    localparam int c_PW    = DW + 4;
    localparam int c_SW    = DW + 5;
    localparam int c_BW    = $clog2(DELAY_MAX + 3);
    localparam int c_EW    = 2 * DW + 2;

    localparam logic signed [DW-1:0]   c_MAX   = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0]   c_MIN   = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [c_SW-1:0] c_MAX_W = c_SW'(c_MAX);
    localparam logic signed [c_SW-1:0] c_MIN_W = c_SW'(c_MIN);
    localparam logic [c_BW-1:0]        c_BLANK = c_BW'(DELAY_MAX + 2);

    logic signed [DW-1:0]   w_negI, w_negQ, w_rotI, w_rotQ;
    logic                   w_negI_sat, w_negQ_sat, w_rot_sat;
    logic signed [c_PW-1:0] w_gain, w_prodI, w_prodQ;

    logic signed [c_PW-1:0] r_s1_I, r_s1_Q;
    logic                   r_s1_valid, r_s1_sat;

    logic signed [NOISE_BITS-1:0] w_noiseI, w_noiseQ;
    logic signed [c_SW-1:0]       w_sumI, w_sumQ;
    logic signed [DW-1:0]         w_clpI, w_clpQ;
    logic                         w_satI, w_satQ;

    logic signed [DW-1:0] r_s2_I, r_s2_Q;
    logic                 r_s2_valid, r_s2_sat;

    logic [15:0]         r_lfsr;
    logic [c_EW-1:0]     r_mem [DELAY_MAX];
    logic [c_DLY_W-1:0]  r_wptr, r_delay, w_dly, w_rptr;
    logic                r_armed;
    logic [c_BW-1:0]     r_blank;
    logic [15:0]         r_sat_cnt;
    logic [c_EW-1:0]     w_s2_word, w_tap;
    logic                w_blank, w_tap_sat;

    // Stage 1: quadrant rotation with saturating negation, then gain/4
    always_comb begin
        w_negI_sat = (in_I == c_MIN);
        w_negQ_sat = (in_Q == c_MIN);
        w_negI     = w_negI_sat ? c_MAX : -in_I;
        w_negQ     = w_negQ_sat ? c_MAX : -in_Q;
        case (cfg_rot)
            2'd0: begin w_rotI = in_I;   w_rotQ = in_Q;   w_rot_sat = 1'b0;                    end
            2'd1: begin w_rotI = in_Q;   w_rotQ = w_negI; w_rot_sat = w_negI_sat;              end
            2'd2: begin w_rotI = w_negI; w_rotQ = w_negQ; w_rot_sat = w_negI_sat | w_negQ_sat; end
            default: begin w_rotI = w_negQ; w_rotQ = in_I; w_rot_sat = w_negQ_sat;            end
        endcase
        w_gain  = c_PW'({1'b0, cfg_gain});
        w_prodI = c_PW'(w_rotI) * w_gain;
        w_prodQ = c_PW'(w_rotQ) * w_gain;
    end

    // Stage 2: offset plus noise at full width, then clamp to DW bits
    always_comb begin
        w_noiseI = cfg_noise_en ? {~r_lfsr[NOISE_BITS-1], r_lfsr[NOISE_BITS-2:0]} : '0;
        w_noiseQ = cfg_noise_en ? {~r_lfsr[15], r_lfsr[14 -: NOISE_BITS-1]} : '0;
        w_sumI   = c_SW'(r_s1_I) + c_SW'(cfg_dc_I) + c_SW'(w_noiseI);
        w_sumQ   = c_SW'(r_s1_Q) + c_SW'(cfg_dc_Q) + c_SW'(w_noiseQ);
        w_satI   = (w_sumI > c_MAX_W) || (w_sumI < c_MIN_W);
        w_satQ   = (w_sumQ > c_MAX_W) || (w_sumQ < c_MIN_W);
        w_clpI   = (w_sumI > c_MAX_W) ? c_MAX : (w_sumI < c_MIN_W) ? c_MIN : w_sumI[DW-1:0];
        w_clpQ   = (w_sumQ > c_MAX_W) ? c_MAX : (w_sumQ < c_MIN_W) ? c_MIN : w_sumQ[DW-1:0];
    end

    always_ff @(posedge clk_16M384 or posedge rst_16M384) begin
        if (rst_16M384) begin
            r_s1_I     <= '0;
            r_s1_Q     <= '0;
            r_s1_valid <= 1'b0;
            r_s1_sat   <= 1'b0;
            r_s2_I     <= '0;
            r_s2_Q     <= '0;
            r_s2_valid <= 1'b0;
            r_s2_sat   <= 1'b0;
            r_lfsr     <= LFSR_SEED;
        end else begin
            r_s1_I     <= w_prodI >>> 2;
            r_s1_Q     <= w_prodQ >>> 2;
            r_s1_valid <= in_valid;
            r_s1_sat   <= in_valid & w_rot_sat;
            r_lfsr     <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
            // Invalid samples are zeroed so offset and noise never leak out
            if (r_s1_valid) begin
                r_s2_I     <= w_clpI;
                r_s2_Q     <= w_clpQ;
                r_s2_valid <= 1'b1;
                r_s2_sat   <= r_s1_sat | w_satI | w_satQ;
            end else begin
                r_s2_I     <= '0;
                r_s2_Q     <= '0;
                r_s2_valid <= 1'b0;
                r_s2_sat   <= 1'b0;
            end
        end
    end

    // Pointer arithmetic wraps naturally because DELAY_MAX is a power of two
    always_comb begin
        w_dly     = r_armed ? r_delay : cfg_delay;
        w_rptr    = r_wptr - w_dly;
        w_s2_word = {r_s2_valid, r_s2_sat, r_s2_I, r_s2_Q};
        w_tap     = (w_dly == '0) ? w_s2_word : r_mem[w_rptr];
        w_blank   = (r_blank != '0);
        w_tap_sat = w_tap[c_EW-2];
        out_valid = w_tap[c_EW-1] & ~w_blank;
        out_I     = w_blank ? '0 : w_tap[2*DW-1:DW];
        out_Q     = w_blank ? '0 : w_tap[DW-1:0];
        sat_cnt   = r_sat_cnt;
    end

    always_ff @(posedge clk_16M384 or posedge rst_16M384) begin
        if (rst_16M384) begin
            for (int k = 0; k < DELAY_MAX; k++) begin
                r_mem[k] <= '0;
            end
            r_wptr    <= '0;
            r_delay   <= '0;
            r_armed   <= 1'b0;
            r_blank   <= '0;
            r_sat_cnt <= '0;
        end else begin
            r_mem[r_wptr] <= w_s2_word;
            r_wptr        <= r_wptr + c_DLY_W'(1);
            // First clock after reset adopts cfg_delay silently; later changes blank
            if (!r_armed) begin
                r_armed <= 1'b1;
                r_delay <= cfg_delay;
            end else if (cfg_delay != r_delay) begin
                r_delay <= cfg_delay;
                r_blank <= c_BLANK;
            end else if (w_blank) begin
                r_blank <= r_blank - c_BW'(1);
            end
            if (out_valid && w_tap_sat && (r_sat_cnt != 16'hFFFF)) begin
                r_sat_cnt <= r_sat_cnt + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_chan_emu_iq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_chan_emu_iq : scoreboard bench for chan_emu_iq.
// Rev 1.0
// ============================================================================
module tb_chan_emu_iq;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [11:0] in_I = '0, in_Q = '0;
    logic               in_valid = 1'b0;
    logic [1:0]         cfg_rot = '0;
    logic [3:0]         cfg_gain = '0;
    logic signed [7:0]  cfg_dc_I = '0, cfg_dc_Q = '0;
    logic               cfg_noise_en = 1'b0;
    logic [3:0]         cfg_delay = '0;
    logic signed [11:0] out_I, out_Q;
    logic               out_valid;
    logic [15:0]        sat_cnt;

    chan_emu_iq dut (
        .clk_16M384   (clk),
        .rst_16M384   (rst),
        .in_I         (in_I),
        .in_Q         (in_Q),
        .in_valid     (in_valid),
        .cfg_rot      (cfg_rot),
        .cfg_gain     (cfg_gain),
        .cfg_dc_I     (cfg_dc_I),
        .cfg_dc_Q     (cfg_dc_Q),
        .cfg_noise_en (cfg_noise_en),
        .cfg_delay    (cfg_delay),
        .out_I        (out_I),
        .out_Q        (out_Q),
        .out_valid    (out_valid),
        .sat_cnt      (sat_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                 cyc;
        logic signed [11:0] i;
        logic signed [11:0] q;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   exp_sat = 0;
    int   cur_delay = 0;
    bit   sb_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: rotation, floor(x*g/4), offset, clamp (noise disabled)
    function automatic void model(input int i, input int q, input int rot, input int gain,
                                  input int dci, input int dcq,
                                  output int oi, output int oq, output bit sat);
        int ni, nq, ri, rq, si, sq;
        bit s;
        ni = (i == -2048) ? 2047 : -i;
        nq = (q == -2048) ? 2047 : -q;
        case (rot)
            0: begin ri = i;  rq = q;  s = 1'b0; end
            1: begin ri = q;  rq = ni; s = (i == -2048); end
            2: begin ri = ni; rq = nq; s = (i == -2048) || (q == -2048); end
            default: begin ri = nq; rq = i; s = (q == -2048); end
        endcase
        si = ((ri * gain) >>> 2) + dci;
        sq = ((rq * gain) >>> 2) + dcq;
        if (si > 2047 || si < -2048 || sq > 2047 || sq < -2048) s = 1'b1;
        oi  = (si > 2047) ? 2047 : (si < -2048) ? -2048 : si;
        oq  = (sq > 2047) ? 2047 : (sq < -2048) ? -2048 : sq;
        sat = s;
    endfunction

    // Scoreboard: each cycle either the due sample or an all-zero idle output
    always @(negedge clk) begin
        if (sb_on) begin
            while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                mon_e = sbq.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_sample due=%0d now=%0d want I=%0d Q=%0d", mon_e.cyc, cyc, mon_e.i, mon_e.q);
            end
            checks++;
            if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
                mon_e = sbq.pop_front();
                if (out_valid !== 1'b1 || out_I !== mon_e.i || out_Q !== mon_e.q) begin
                    errors++;
                    $display("FAIL sample cyc=%0d got v=%0b I=%0d Q=%0d want v=1 I=%0d Q=%0d",
                             cyc, out_valid, out_I, out_Q, mon_e.i, mon_e.q);
                end
            end else if (out_valid !== 1'b0 || out_I !== 12'sd0 || out_Q !== 12'sd0) begin
                errors++;
                $display("FAIL idle cyc=%0d got v=%0b I=%0d Q=%0d want v=0 I=0 Q=0", cyc, out_valid, out_I, out_Q);
            end
        end
    end

    task automatic drive(input logic v, input int i, input int q);
        int   oi, oq;
        bit   s;
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = v;
        in_I     = 12'(i);
        in_Q     = 12'(q);
        if (v) begin
            model(i, q, cfg_rot, cfg_gain, cfg_dc_I, cfg_dc_Q, oi, oq, s);
            e.cyc = cyc + 2 + cur_delay;
            e.i   = 12'(oi);
            e.q   = 12'(oq);
            sbq.push_back(e);
            if (s) exp_sat++;
        end
    endtask

    task automatic do_reset(input int dly);
        @(posedge clk);
        #1;
        sb_on     = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        cfg_delay = 4'(dly);
        cur_delay = dly;
        sbq.delete();
        exp_sat   = 0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_I !== 12'sd0 || out_Q !== 12'sd0 || sat_cnt !== 16'd0) begin
            errors++;
            $display("FAIL async_reset got v=%0b I=%0d Q=%0d sat=%0d want all 0", out_valid, out_I, out_Q, sat_cnt);
        end
        repeat (2) @(posedge clk);
        #1;
        rst   = 1'b0;
        sb_on = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (10) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || out_I !== 12'sd0 || out_Q !== 12'sd0 || sat_cnt !== 16'd0) begin
                errors++;
                $display("FAIL reset_idle got v=%0b I=%0d Q=%0d sat=%0d want all 0", out_valid, out_I, out_Q, sat_cnt);
            end
        end
        @(posedge clk);
        #1;
        rst   = 1'b0;
        sb_on = 1'b1;
        repeat (6) drive(1'b0, 0, 0);
        checks++;
        if (sat_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_satcnt got %0d want 0", sat_cnt);
        end
    endtask

    task automatic test_rotate_gain();
        cfg_rot = 2'd1; cfg_gain = 4'd3; cfg_dc_I = '0; cfg_dc_Q = '0; cfg_noise_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 400, -200);
            if (k == 2) begin
                @(negedge clk);
                checks++;
                if (out_valid !== 1'b1 || out_I !== -12'sd150 || out_Q !== -12'sd300) begin
                    errors++;
                    $display("FAIL rot1_gain3 got v=%0b I=%0d Q=%0d want v=1 I=-150 Q=-300", out_valid, out_I, out_Q);
                end
            end
        end
        repeat (3) drive(1'b0, 0, 0);
        for (int r = 0; r < 4; r++) begin
            cfg_rot = 2'(r); cfg_gain = 4'd7; cfg_dc_I = 8'sd5; cfg_dc_Q = -8'sd7;
            drive(1'b1, 400, -200);
            drive(1'b1, -1023, 777);
            drive(1'b1, 3, -3);
            repeat (3) drive(1'b0, 0, 0);
        end
    endtask

    task automatic test_delay();
        do_reset(5);
        cfg_rot = 2'd0; cfg_gain = 4'd4; cfg_dc_I = '0; cfg_dc_Q = '0;
        drive(1'b1, 100, 0);
        repeat (12) drive(1'b0, 0, 0);
    endtask

    task automatic test_saturation();
        do_reset(0);
        cfg_rot = 2'd0; cfg_gain = 4'd8; cfg_dc_I = 8'sd100; cfg_dc_Q = '0;
        repeat (3) drive(1'b1, 2047, 0);
        repeat (4) drive(1'b0, 0, 0);
        checks++;
        if (sat_cnt !== 16'd3) begin
            errors++;
            $display("FAIL sat_gain got %0d want 3", sat_cnt);
        end
        cfg_rot = 2'd2; cfg_gain = 4'd4;
        drive(1'b1, -2048, 0);
        repeat (4) drive(1'b0, 0, 0);
        checks++;
        if (sat_cnt !== 16'd4) begin
            errors++;
            $display("FAIL sat_negate got %0d want 4", sat_cnt);
        end
    endtask

    task automatic test_delay_change();
        int   n0, n;
        exp_t e;
        do_reset(2);
        cfg_rot = 2'd0; cfg_gain = 4'd4; cfg_dc_I = '0; cfg_dc_Q = '0;
        n0 = 0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) n0 = cyc;
            n = cyc;
            if (k == 20) begin
                cfg_delay = 4'd9;
                cur_delay = 9;
            end
            in_valid = 1'b1;
            in_I     = 12'(k * 10 - 200);
            in_Q     = 12'(7 - k);
            e.i = in_I;
            e.q = in_Q;
            // Change seen at the edge after n0+20: 18 blank cycles, then latency 11
            if (n + 4 <= n0 + 20) begin
                e.cyc = n + 4;
                sbq.push_back(e);
            end else if (n + 11 >= n0 + 39) begin
                e.cyc = n + 11;
                sbq.push_back(e);
            end
        end
        repeat (15) drive(1'b0, 0, 0);
    endtask

    task automatic test_back_to_back();
        int i, q;
        do_reset(0);
        for (int b = 0; b < 12; b++) begin
            cfg_rot  = 2'($urandom_range(0, 3));
            cfg_gain = 4'($urandom_range(0, 15));
            cfg_dc_I = 8'($urandom_range(0, 255));
            cfg_dc_Q = 8'($urandom_range(0, 255));
            for (int k = 0; k < 8; k++) begin
                case ($urandom_range(0, 3))
                    0: i = -2048;
                    1: i = 2047;
                    default: i = int'($urandom_range(0, 4095)) - 2048;
                endcase
                q = (k % 3 == 0) ? -2048 : int'($urandom_range(0, 4095)) - 2048;
                drive(($urandom_range(0, 4) != 0), i, q);
            end
            repeat (3) drive(1'b0, 0, 0);
        end
        repeat (2) drive(1'b0, 0, 0);
        checks++;
        if (sat_cnt !== 16'(exp_sat)) begin
            errors++;
            $display("FAIL b2b_satcnt got %0d want %0d", sat_cnt, exp_sat);
        end
    endtask

    task automatic test_noise();
        logic signed [11:0] recI[$], recQ[$];
        int sumI, sumQ, idx, bad;
        do_reset(0);
        sb_on = 1'b0;
        cfg_rot = 2'd0; cfg_gain = 4'd0; cfg_dc_I = '0; cfg_dc_Q = '0; cfg_noise_en = 1'b1;
        sumI = 0; sumQ = 0; bad = 0;
        for (int k = 0; k < 10000; k++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            in_I     = 12'(k);
            in_Q     = 12'(-k);
            @(negedge clk);
            if (out_valid === 1'b1) begin
                recI.push_back(out_I);
                recQ.push_back(out_Q);
                sumI += int'(out_I);
                sumQ += int'(out_Q);
                if (out_I < -12'sd32 || out_I > 12'sd31 || out_Q < -12'sd32 || out_Q > 12'sd31) bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL noise_range got %0d out-of-range samples want 0", bad);
        end
        checks++;
        if (recI.size() < 9990) begin
            errors++;
            $display("FAIL noise_count got %0d valid samples want >= 9990", recI.size());
        end
        checks++;
        if (sumI >= 2 * recI.size() || -sumI >= 2 * recI.size() ||
            sumQ >= 2 * recI.size() || -sumQ >= 2 * recI.size()) begin
            errors++;
            $display("FAIL noise_mean got sumI=%0d sumQ=%0d over %0d want |mean|<2", sumI, sumQ, recI.size());
        end
        do_reset(0);
        sb_on = 1'b0;
        idx = 0; bad = 0;
        for (int k = 0; k < 10000; k++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            in_I     = 12'(k);
            in_Q     = 12'(-k);
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (idx >= recI.size() || out_I !== recI[idx] || out_Q !== recQ[idx]) bad++;
                idx++;
            end
        end
        checks++;
        if (bad != 0 || idx != recI.size()) begin
            errors++;
            $display("FAIL noise_replay got %0d differing of %0d want 0 of %0d", bad, idx, recI.size());
        end
        in_valid     = 1'b0;
        cfg_noise_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rotate_gain();
        test_delay();
        test_saturation();
        test_delay_change();
        test_back_to_back();
        test_noise();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
